// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared definitions for the seven-segment display path. Holds the
//            active-low segment patterns (identical to the display encoder's),
//            the segment bit order, the digit count, the digit-capture state
//            encoding and a helper that decodes an active-low anode vector.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions inside the 7-bit bus {a,b,c,d,e,f,g}
  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  // Active-low patterns (0 = segment lit)
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Per-digit capture state
  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } dig_state_t;

  typedef struct packed {
    logic       valid;  // exactly one anode is low
    logic [1:0] idx;    // which digit that anode selects
  } sel_t;

  // Decode an active-low anode vector; anything other than a single low bit
  // is treated as a blank scan slot.
  function automatic sel_t sel_decode(input logic [3:0] an);
    sel_t s;
    s.valid = 1'b1;
    s.idx   = 2'd0;
    case (an)
      4'b1110: s.idx = 2'd0;
      4'b1101: s.idx = 2'd1;
      4'b1011: s.idx = 2'd2;
      4'b0111: s.idx = 2'd3;
      default: s.valid = 1'b0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_pattern_lookup.sv
`default_nettype none
// ============================================================================
// Module   : seg_pattern_lookup
// Purpose  : Inverse of the display encoder: maps an active-low 7-segment
//            pattern back to its hex nibble. B and D share no unique pattern
//            and are never produced; unknown patterns give nibble 0, bad=1.
// Ports    : seg    in  7  active-low segments {a..g}, a at bit 6
//            nibble out 4  decoded hex value
//            bad    out 1  pattern not recognised
// Revision : 1.0 - initial release
// ============================================================================
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       bad
);

  always_comb begin
    nibble = 4'h0;
    bad    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_C:   nibble = 4'hC;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: bad    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture
// Purpose  : Watches the multiplexed 4-digit seven-segment bus, debounces each
//            scan slot, decodes the digit shown and assembles complete frames
//            that are offered on a valid/ready handshake.
// Ports    : clk          in   1  system clock, rising edge
//            rst          in   1  synchronous active-high reset
//            an           in   4  anode selects, active-low
//            seg          in   7  segments, active-low {a..g}
//            frame        out 16  digit i in frame[4i+3:4i]
//            frame_bad    out  4  per-digit unrecognised-pattern flags
//            frame_valid  out  1  frame held and not yet accepted
//            frame_ready  in   1  consumer accept
//            overrun      out  1  one-cycle pulse, a completed frame dropped
//            idle         out  1  no valid select for TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] frame,
  output logic [3:0]  frame_bad,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  output logic        idle
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

  // Sample stage plus the previous sample, used for change detection
  logic [3:0] an_s, an_p;
  logic [6:0] seg_s, seg_p;

  dig_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TO_W-1:0]  tcnt, tcnt_nx;
  logic [3:0]       mask, mask_nx;
  logic [3:0]       nib_slot [NUM_DIGITS];
  logic [3:0]       bad_slot;

  sel_t       sel;
  logic       same;
  logic       capture;
  logic       complete;
  logic       load;
  logic       timeout_hit;
  logic [3:0] lk_nibble;
  logic       lk_bad;

  seg_pattern_lookup u_lookup (
    .seg    (seg_s),
    .nibble (lk_nibble),
    .bad    (lk_bad)
  );

  assign sel  = sel_decode(an_s);
  assign same = ({an_s, seg_s} == {an_p, seg_p});

  // Digit debounce FSM: next state and capture strobe
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      ST_BLANK: begin
        cnt_nx = '0;
        if (sel.valid) begin
          state_nx = ST_SETTLE;
          cnt_nx   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!sel.valid) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end else if (!same) begin
          cnt_nx = CNT_W'(1);
        end else if (cnt == CNT_LAST) begin
          // This sample is the STABLE_CYCLES-th identical one
          capture  = 1'b1;
          state_nx = ST_HELD;
          cnt_nx   = CNT_FULL;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!sel.valid) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end else if (!same) begin
          state_nx = ST_SETTLE;
          cnt_nx   = CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  // Frame completion, timeout and mask bookkeeping
  always_comb begin
    complete    = (mask == 4'b1111);
    load        = complete && (!frame_valid || frame_ready);
    tcnt_nx     = sel.valid ? '0 : ((tcnt == TO_MAX) ? tcnt : tcnt + TO_W'(1));
    timeout_hit = !sel.valid && (tcnt_nx == TO_MAX);
    mask_nx     = complete ? 4'b0000 : mask;
    if (capture) begin
      mask_nx[sel.idx] = 1'b1;
    end
    if (timeout_hit) begin
      mask_nx = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s        <= 4'hF;
      seg_s       <= SEG_BLANK;
      an_p        <= 4'hF;
      seg_p       <= SEG_BLANK;
      state       <= ST_BLANK;
      cnt         <= '0;
      tcnt        <= '0;
      mask        <= '0;
      bad_slot    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        nib_slot[i] <= '0;
      end
      frame       <= '0;
      frame_bad   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      idle        <= 1'b1;
    end else begin
      an_s  <= an;
      seg_s <= seg;
      an_p  <= an_s;
      seg_p <= seg_s;
      state <= state_nx;
      cnt   <= cnt_nx;
      tcnt  <= tcnt_nx;
      mask  <= mask_nx;

      if (capture) begin
        nib_slot[sel.idx] <= lk_nibble;
        bad_slot[sel.idx] <= lk_bad;
      end

      if (sel.valid) begin
        idle <= 1'b0;
      end else if (timeout_hit) begin
        idle <= 1'b1;
      end

      if (load) begin
        frame       <= {nib_slot[3], nib_slot[2], nib_slot[1], nib_slot[0]};
        frame_bad   <= bad_slot;
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end

      overrun <= complete && !load;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_capture.md
# seg_scan_capture

Captures the multiplexed 4-digit seven-segment bus (active-low anodes plus shared active-low segments), as driven by the display scanner, and reconstructs the displayed hex frame. This lets the rest of the design, and the self-checking benches, read back what the display actually shows. It debounces scan transitions, inverts the segment encoding, collects all four digits into a frame and presents it on a valid/ready handshake.

## Interface
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured (≥2).
- TIMEOUT, 65536: cycles without a valid digit select before the partial frame is discarded (≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- an  in  4  anode selects, active-low; an[i]=0 selects digit i.
- seg  in  7  segments, active-low, order {a,b,c,d,e,f,g}, a at bit 6.
- frame  out  16  captured digits, digit i in frame[4i+3:4i].
- frame_bad  out  4  per-digit flag: the pattern was unrecognised, so that nibble reads 0.
- frame_valid  out  1  frame/frame_bad hold a frame not yet accepted.
- frame_ready  in  1  consumer accepts when frame_valid && frame_ready.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- idle  out  1  no valid digit select seen for TIMEOUT cycles.

## Operation
- {an,seg} are registered once (sample stage); all logic works on the sample.
- Valid select: exactly one bit of the sampled an is 0. A sample with zero or several bits low is blank.
- Pattern map (active-low abcdefg → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7.
  - 0000000→8, 0000100→9, 0001000→A, 0110001→C, 0110000→E, 0111000→F.
  - B and D have no unique pattern and are never produced.
  - Any other pattern → nibble 0, bad=1.
- Digit FSM:
  - BLANK: stay while the sample is blank. A valid select → SETTLE with cnt=1.
  - SETTLE: if the sample equals the previous sample, cnt++. On any change → SETTLE with cnt=1, or BLANK if the new sample is blank.
  - When cnt reaches STABLE_CYCLES, capture: write the nibble and bad bit into digit slot i, set mask[i], go to HELD.
  - HELD: stay while the sample is unchanged. On a change → SETTLE (cnt=1) or BLANK.
- Recapturing a digit already in mask overwrites its slot; the mask is unchanged.
- Frame completion:
  - A frame completes in the cycle mask becomes 4'b1111. mask clears on the next edge.
  - If the output buffer is empty, or is being accepted in that same cycle, load frame/frame_bad and set frame_valid.
  - Otherwise drop the new frame, keep the old one and pulse overrun.
- frame_valid clears on acceptance unless a new frame loads in the same cycle.
- Timeout:
  - The timeout counter resets on every valid-select sample and otherwise increments, saturating.
  - At TIMEOUT: clear mask, set idle. idle clears on the next valid-select sample.
  - Digit slots are kept; only the mask is cleared.

## Timing
- Reset values: frame=0, frame_bad=0, frame_valid=0, overrun=0, idle=1, mask=0, FSM=BLANK, counters=0.
- Capture latency: the slot is written at edge N+STABLE_CYCLES when the pattern is first present at the pins before edge N (sample stage is one cycle).
- Frame latency: frame_valid rises one cycle after the capture that completes the mask.
- A glitch of fewer than STABLE_CYCLES samples never captures.
- Reset mid-settle or mid-frame discards everything; no overrun pulse.
- cnt width is clog2(STABLE_CYCLES+1) and saturates in HELD. The timeout counter width is clog2(TIMEOUT+1).

## Structure
- Shared package seg_pkg: SEG_* active-low pattern constants (the same ones the display encoder uses), the segment bit-order constants and the digit-count constant 4.
- Sub-module seg_pattern_lookup: combinational 7-bit pattern → {bad, nibble[3:0]}. Instantiated once, on the sample stage.

## Test plan
- Scan digits 0..3 showing 1,2,3,4, each held 20 cycles, frame_ready=1 → frame=16'h4321, frame_bad=0, a single frame_valid pulse.
- Digit 2 held only 10 cycles (STABLE_CYCLES=16), the others 20 → no capture of digit 2 and no frame until digit 2 is re-scanned for 16 or more cycles.
- Digit 1 pattern 1111111 → frame[7:4]=0, frame_bad=4'b0010.
- frame_ready=0, two full scans → first frame held, overrun pulses once; assert frame_ready → the first frame is accepted, then frame_valid=0.
- Scan digits 0 and 1 only, then an=4'b1111 for TIMEOUT cycles → idle=1, mask cleared; a subsequent full scan yields one frame.
- an=4'b1100 (two selects) held 50 cycles → no capture, timeout counter keeps running.
